rvvi_retire_reorder_ctrl: RTL and testbench

- Sequencing controller between trace-record producers and the RVVI retire interface of the coverage testbench.
- Accepts parsed retire records tagged with ORDER, possibly out of order from parallel trace readers.
- Buffers records in an ORDER-indexed window and emits them strictly in ascending ORDER, one per cycle, with valid/ready.
- Tracks end-of-trace drain and reports duplicate, out-of-window and gap errors so the testbench can $finish cleanly.

---
 rtl/rvvi_reorder_pkg.sv | 31 +++
 rtl/reorder_slot_mem.sv | 46 ++++
 rtl/rvvi_retire_reorder_ctrl.sv | 146 ++++++++++++++
 tb/tb_rvvi_retire_reorder_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvvi_reorder_pkg.sv
// Shared types for the RVVI retire reorder controller: record layout, FSM states, error bits.
`ifndef RVVI_XLEN
`define RVVI_XLEN 64
`endif
`ifndef RVVI_ORDERW
`define RVVI_ORDERW 64
`endif

package rvvi_reorder_pkg;

  typedef struct packed {
    logic [`RVVI_ORDERW-1:0] order;
    logic [31:0]             insn;
    logic [`RVVI_XLEN-1:0]   pc;
    logic                    trap;
    logic [1:0]              mode;
  } retire_rec_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int ERR_DUP   = 0;
  localparam int ERR_RANGE = 1;
  localparam int ERR_GAP   = 2;
  localparam int ERR_N     = 3;

endpackage

// File: rtl/reorder_slot_mem.sv
// ORDER-indexed record window: one write port, one read port with same-cycle write-to-read bypass.
module reorder_slot_mem
  import rvvi_reorder_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  retire_rec_t       wdata,
  input  logic [AW-1:0]     raddr,
  input  logic              rclr,
  output logic              rvalid,
  output retire_rec_t       rdata,
  output logic [DEPTH-1:0]  valid
);

  retire_rec_t      slots_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic             bypass;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid_q <= '0;
    end else begin
      if (we)   valid_q[waddr] <= 1'b1;
      // A bypassed write is consumed in the same cycle, so the clear must win.
      if (rclr) valid_q[raddr] <= 1'b0;
    end
  end

  // NOTE: the payload array is not reset; valid_q alone decides whether an entry means anything.
  always_ff @(posedge clk) begin
    if (we) slots_q[waddr] <= wdata;
  end

  assign bypass = we && (waddr == raddr);
  assign rvalid = valid_q[raddr] | bypass;
  assign rdata  = bypass ? wdata : slots_q[raddr];
  assign valid  = valid_q;

endmodule

// File: rtl/rvvi_retire_reorder_ctrl.sv
// Reorders ORDER-tagged retire records into strictly ascending ORDER for the RVVI retire interface.
module rvvi_retire_reorder_ctrl
  import rvvi_reorder_pkg::*;
#(
  parameter int XLEN   = `RVVI_XLEN,
  parameter int DEPTH  = 16,
  parameter int ORDERW = `RVVI_ORDERW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ORDERW-1:0]       cfg_base_order,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ORDERW-1:0]       in_order,
  input  logic [31:0]             in_insn,
  input  logic [XLEN-1:0]         in_pc,
  input  logic                    in_trap,
  input  logic [1:0]              in_mode,
  input  logic                    end_of_trace,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ORDERW-1:0]       out_order,
  output logic [31:0]             out_insn,
  output logic [XLEN-1:0]         out_pc,
  output logic                    out_trap,
  output logic [1:0]              out_mode,
  output logic                    done,
  output logic                    err_dup,
  output logic                    err_range,
  output logic                    err_gap,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int                AW      = $clog2(DEPTH);
  localparam int                OW      = AW + 1;
  localparam logic [ORDERW-1:0] DEPTH_O = ORDERW'(DEPTH);

  state_t            state_q, state_d;
  logic [ORDERW-1:0] next_q;
  logic [OW-1:0]     occ_q;
  logic [ERR_N-1:0]  err_q, err_set;
  logic              done_q;
  logic              out_valid_q;
  retire_rec_t       out_rec_q, in_rec, rd_rec;

  logic [DEPTH-1:0]  slot_valid;
  logic [AW-1:0]     widx, ridx;
  logic              accept, in_win, slot_busy, wr_en;
  logic              rd_valid, active, out_free, load, drain_end;

  assign in_rec    = {in_order, in_insn, in_pc, in_trap, in_mode};
  assign widx      = in_order[AW-1:0];
  assign ridx      = next_q[AW-1:0];
  // Unsigned wrap-around distance keeps the window test correct across ORDER overflow.
  assign in_win    = (in_order - next_q) < DEPTH_O;
  assign accept    = in_valid && in_ready;
  assign slot_busy = slot_valid[widx];
  assign wr_en     = accept && in_win && !slot_busy;

  assign active    = (state_q == RUN) || (state_q == DRAIN);
  assign out_free  = !out_valid_q || out_ready;
  assign load      = active && out_free && rd_valid;
  // Drain ends once nothing is loadable at next_q and the output stage has been handed off.
  assign drain_end = (state_q == DRAIN) && out_free && !rd_valid;

  assign err_set[ERR_DUP]   = accept && in_win && slot_busy;
  assign err_set[ERR_RANGE] = accept && !in_win;
  assign err_set[ERR_GAP]   = drain_end && (occ_q != '0);

  reorder_slot_mem #(.DEPTH(DEPTH)) u_slots (
    .clk    (clk),
    .reset  (reset),
    .clear  (start),
    .we     (wr_en),
    .waddr  (widx),
    .wdata  (in_rec),
    .raddr  (ridx),
    .rclr   (load),
    .rvalid (rd_valid),
    .rdata  (rd_rec),
    .valid  (slot_valid)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first so no latches are inferred.
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE:  ;
      RUN: begin
        in_ready = 1'b1;
        if (end_of_trace) state_d = DRAIN;
      end
      DRAIN: if (drain_end) state_d = DONE;
      DONE:  ;
      default: state_d = IDLE;
    endcase
    if (start) state_d = RUN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      next_q      <= '0;
      occ_q       <= '0;
      err_q       <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_rec_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        next_q      <= cfg_base_order;
        occ_q       <= '0;
        err_q       <= '0;
        done_q      <= 1'b0;
        out_valid_q <= 1'b0;
      end else begin
        err_q  <= err_q | err_set;
        done_q <= done_q | (state_q == DONE);
        occ_q  <= occ_q + OW'(wr_en) - OW'(load);
        if (load) begin
          next_q      <= next_q + ORDERW'(1);
          out_valid_q <= 1'b1;
          out_rec_q   <= rd_rec;
        end else if (out_ready) begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_order = out_rec_q.order;
  assign out_insn  = out_rec_q.insn;
  assign out_pc    = out_rec_q.pc;
  assign out_trap  = out_rec_q.trap;
  assign out_mode  = out_rec_q.mode;
  assign done      = done_q;
  assign err_dup   = err_q[ERR_DUP];
  assign err_range = err_q[ERR_RANGE];
  assign err_gap   = err_q[ERR_GAP];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_rvvi_retire_reorder_ctrl.sv
// Scoreboard bench: a sorted-release reference model feeds an expected queue drained by a monitor.
module tb_rvvi_retire_reorder_ctrl;

  localparam int DEPTH = 16;

  typedef struct {
    bit [63:0] order;
    bit [31:0] insn;
    bit [63:0] pc;
    bit        trap;
    bit [1:0]  mode;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0, in_valid = 1'b0, in_trap = 1'b0, end_of_trace = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_trap, done, err_dup, err_range, err_gap;
  logic [63:0] cfg_base_order = '0, in_order = '0, in_pc = '0;
  logic [63:0] out_order, out_pc;
  logic [31:0] in_insn = '0, out_insn;
  logic [1:0]  in_mode = '0, out_mode;
  logic [4:0]  occupancy;

  int          checks = 0;
  int          errors = 0;
  rec_t        exp_q[$];
  rec_t        pend[bit [63:0]];
  bit [63:0]   m_next = '0, consumed_next = '0;
  bit          m_dup = 1'b0, m_range = 1'b0;
  bit          rand_rdy = 1'b0, rdy_dir = 1'b1;
  bit          prev_stall = 1'b0;
  logic [63:0] prev_order = '0;
  logic [127:0] prev_body = '0;

  always #5 clk = ~clk;

  rvvi_retire_reorder_ctrl #(.XLEN(64), .DEPTH(DEPTH), .ORDERW(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .cfg_base_order (cfg_base_order),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_order       (in_order),
    .in_insn        (in_insn),
    .in_pc          (in_pc),
    .in_trap        (in_trap),
    .in_mode        (in_mode),
    .end_of_trace   (end_of_trace),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_order      (out_order),
    .out_insn       (out_insn),
    .out_pc         (out_pc),
    .out_trap       (out_trap),
    .out_mode       (out_mode),
    .done           (done),
    .err_dup        (err_dup),
    .err_range      (err_range),
    .err_gap        (err_gap),
    .occupancy      (occupancy)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Consumer readiness changes just after the active edge.
  always @(posedge clk) begin
    #2;
    out_ready = rand_rdy ? ($urandom_range(0, 9) < 7) : rdy_dir;
  end

  // Monitor: pops the expected stream on every handshake and checks stability under backpressure.
  initial begin : monitor
    rec_t e;
    forever begin
      @(negedge clk);
      #1;
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_order", out_order, prev_order);
        check("hold_data", {out_insn, out_pc, out_trap, out_mode}, prev_body);
      end
      if (out_valid && out_ready && !reset) begin
        check("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_order", out_order, e.order);
          check("out_data", {out_insn, out_pc, out_trap, out_mode}, {e.insn, e.pc, e.trap, e.mode});
          consumed_next = e.order + 64'd1;
        end
      end
      prev_stall = out_valid && !out_ready && !reset;
      prev_order = out_order;
      prev_body  = {out_insn, out_pc, out_trap, out_mode};
    end
  end

  // Reference: a record is released as soon as every smaller ORDER since the base has arrived.
  task automatic model_accept(input rec_t r);
    if (r.order - m_next >= 64'(DEPTH)) m_range = 1'b1;
    else if (pend.exists(r.order)) m_dup = 1'b1;
    else begin
      pend[r.order] = r;
      while (pend.exists(m_next)) begin
        exp_q.push_back(pend[m_next]);
        pend.delete(m_next);
        m_next = m_next + 64'd1;
      end
    end
  endtask

  task automatic send(input bit [63:0] tag, input bit [31:0] insn);
    rec_t r;
    logic rdy;
    r.order = tag;
    r.insn  = insn;
    r.pc    = {$urandom(), $urandom()};
    r.trap  = 1'($urandom());
    r.mode  = 2'($urandom());
    @(negedge clk);
    in_valid = 1'b1;
    in_order = tag;
    in_insn  = insn;
    in_pc    = r.pc;
    in_trap  = r.trap;
    in_mode  = r.mode;
    rdy      = in_ready;
    check("in_ready", rdy, 1);
    @(posedge clk);
    if (rdy === 1'b1) model_accept(r);
    #1 in_valid = 1'b0;
  endtask

  task automatic start_run(input bit [63:0] base);
    @(negedge clk);
    cfg_base_order = base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pend.delete();
    exp_q.delete();
    m_next = base;
    consumed_next = base;
    m_dup = 1'b0;
    m_range = 1'b0;
  endtask

  task automatic finish_run(input string tag);
    int n;
    @(negedge clk);
    end_of_trace = 1'b1;
    @(negedge clk);
    end_of_trace = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    #2;
    check({tag, "_done"}, done, 1);
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_occupancy"}, occupancy, pend.size());
    check({tag, "_err_dup"}, err_dup, m_dup);
    check({tag, "_err_range"}, err_range, m_range);
    check({tag, "_err_gap"}, err_gap, pend.size() != 0);
  endtask

  task automatic check_reset_state();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_order", out_order, 0);
    check("rst_out_data", {out_insn, out_pc, out_trap, out_mode}, 0);
    check("rst_done", done, 0);
    check("rst_errs", {err_dup, err_range, err_gap}, 0);
    check("rst_occupancy", occupancy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 check_reset_state();
    reset = 1'b0;
    pend.delete();
    exp_q.delete();
  endtask

  task automatic random_test();
    int        perm[8];
    int        j, t, w;
    bit [63:0] base, tag;
    rand_rdy = 1'b1;
    base = {$urandom(), 32'hFFFF_FFA0};
    start_run(base);
    for (int b = 0; b < 24; b++) begin
      for (int i = 0; i < 8; i++) perm[i] = i;
      for (int i = 7; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = perm[i];
        perm[i] = perm[j];
        perm[j] = t;
      end
      for (int i = 0; i < 8; i++) begin
        tag = base + 64'(b * 8 + perm[i]);
        w = 0;
        // Stay inside the window the DUT is guaranteed to have open, whatever the backpressure.
        while (tag - consumed_next >= 64'(DEPTH - 1) && w < 400) begin
          @(negedge clk);
          w++;
        end
        check("rand_window_wait", w < 400, 1);
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        send(tag, $urandom());
      end
    end
    rand_rdy = 1'b0;
    rdy_dir = 1'b1;
    finish_run("random");
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    repeat (2) @(negedge clk);
    #1 check_reset_state();
    reset = 1'b0;

    // In-order stream with one-cycle latency and full throughput.
    rdy_dir = 1'b1;
    start_run(64'd100);
    send(64'd100, 32'h100);
    check("first_latency_valid", out_valid, 1);
    check("first_latency_order", out_order, 100);
    for (int i = 101; i < 120; i++) send(64'(i), $urandom());
    check("throughput_order", out_order, 119);
    finish_run("inorder");

    // Permuted window.
    start_run(64'd0);
    send(64'd3, $urandom());
    send(64'd1, $urandom());
    check("perm_occupancy", occupancy, 2);
    check("perm_not_valid", out_valid, 0);
    send(64'd0, $urandom());
    check("perm_first_valid", out_valid, 1);
    check("perm_first_order", out_order, 0);
    send(64'd2, $urandom());
    finish_run("permuted");

    // Backpressure.
    rdy_dir = 1'b0;
    start_run(64'd0);
    for (int i = 0; i < 8; i++) send(64'(i), $urandom());
    check("bp_valid", out_valid, 1);
    check("bp_order", out_order, 0);
    check("bp_occupancy", occupancy, 7);
    rdy_dir = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    check("bp_drained", exp_q.size(), 0);
    check("bp_occupancy_empty", occupancy, 0);
    finish_run("backpressure");

    // Range and duplicate errors; first copy of a duplicate wins.
    start_run(64'd0);
    send(64'd16, $urandom());
    check("err_range_set", err_range, 1);
    check("err_dup_clear", err_dup, 0);
    send(64'd5, 32'hAAAA_0005);
    send(64'd5, 32'hBBBB_0005);
    check("err_dup_set", err_dup, 1);
    for (int i = 0; i < 5; i++) send(64'(i), $urandom());
    send(64'd6, $urandom());
    finish_run("errors");

    // Gap at end of trace.
    start_run(64'd0);
    check("start_clears_done", done, 0);
    check("start_clears_errs", {err_dup, err_range, err_gap}, 0);
    send(64'd0, $urandom());
    send(64'd2, $urandom());
    finish_run("gap");

    // ORDER wrap-around.
    start_run(64'hFFFF_FFFF_FFFF_FFFE);
    send(64'd1, $urandom());
    send(64'd0, $urandom());
    send(64'hFFFF_FFFF_FFFF_FFFF, $urandom());
    send(64'hFFFF_FFFF_FFFF_FFFE, $urandom());
    finish_run("wrap");

    // Reset in the middle of a drain, then a clean restart.
    rdy_dir = 1'b0;
    start_run(64'd0);
    for (int i = 0; i < 4; i++) send(64'(i), $urandom());
    check("mid_occupancy", occupancy, 3);
    @(negedge clk);
    end_of_trace = 1'b1;
    @(negedge clk);
    end_of_trace = 1'b0;
    do_reset();
    rdy_dir = 1'b1;
    @(negedge clk);
    end_of_trace = 1'b1;
    @(negedge clk);
    end_of_trace = 1'b0;
    #1 check("idle_ignores_eot", in_ready, 0);
    start_run(64'd50);
    send(64'd52, $urandom());
    send(64'd50, $urandom());
    send(64'd53, $urandom());
    send(64'd51, $urandom());
    finish_run("restart");

    random_test();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
